// File: rtl/axi_master_write_burst_if.sv
// rtl/axi_master_write_burst_if.sv - AXI4 write channels plus user request/FIFO side of the burst write master.
interface axi_master_write_burst_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 16
);
   logic [ID_W-1:0]     M_AXI_AWID;
   logic [ADDR_W-1:0]   M_AXI_AWADDR;
   logic [7:0]          M_AXI_AWLEN;
   logic [2:0]          M_AXI_AWSIZE;
   logic [1:0]          M_AXI_AWBURST;
   logic                M_AXI_AWLOCK;
   logic [3:0]          M_AXI_AWCACHE;
   logic [2:0]          M_AXI_AWPROT;
   logic [3:0]          M_AXI_AWQOS;
   logic                M_AXI_AWVALID;
   logic                M_AXI_AWREADY;
   logic [DATA_W-1:0]   M_AXI_WDATA;
   logic [DATA_W/8-1:0] M_AXI_WSTRB;
   logic                M_AXI_WLAST;
   logic                M_AXI_WVALID;
   logic                M_AXI_WREADY;
   logic [ID_W-1:0]     M_AXI_BID;
   logic [1:0]          M_AXI_BRESP;
   logic                M_AXI_BVALID;
   logic                M_AXI_BREADY;
   logic                WR_START;
   logic [ADDR_W-1:0]   WR_ADRS;
   logic [LEN_W-1:0]    WR_LEN;
   logic                WR_READY;
   logic                WR_FIFO_RE;
   logic [DATA_W-1:0]   WR_FIFO_DATA;
   logic                WR_DONE;
   logic                WR_ERR;

   modport master (
      output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
             M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
             M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
             WR_READY, WR_FIFO_RE, WR_DONE, WR_ERR,
      input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
             WR_START, WR_ADRS, WR_LEN, WR_FIFO_DATA
   );

   modport slave (
      input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
             M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
             M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
             WR_READY, WR_FIFO_RE, WR_DONE, WR_ERR,
      output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
             WR_START, WR_ADRS, WR_LEN, WR_FIFO_DATA
   );
endinterface

// File: rtl/axi_master_write_burst.sv
// rtl/axi_master_write_burst.sv - splits one user write request into 4 KB-safe AXI4 INCR bursts.
module axi_master_write_burst #(
   parameter int              DATA_W    = 64,
   parameter int              ADDR_W    = 32,
   parameter int              ID_W      = 4,
   parameter logic [ID_W-1:0] AXI_ID    = 4'hF,
   parameter int              MAX_BURST = 128,
   parameter int              LEN_W     = 16
) (
   input logic                       ACLK,
   input logic                       ARESET,
   axi_master_write_burst_if.master  bus
);
   localparam int SZ = $clog2(DATA_W / 8);
   // wide enough for both the user count (+1) and a full 4 KB page in beats
   localparam int CW = (LEN_W + 1 > 13) ? LEN_W + 1 : 13;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << SZ;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic [CW-1:0]     beats_q, beats_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        awlen_q, awlen_d;
   logic              err_q, err_d;

   logic [CW-1:0]     room;
   logic [CW-1:0]     calc_beats;
   logic [ID_W-1:0]   unused_bid;

   assign unused_bid = bus.M_AXI_BID;

   always_comb begin
      room       = CW'((13'd4096 - {1'b0, addr_q[11:0]}) >> SZ);
      calc_beats = CW'(remain_q);
      if (calc_beats > CW'(MAX_BURST)) calc_beats = CW'(MAX_BURST);
      if (calc_beats > room)           calc_beats = room;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         beats_q  <= '0;
         cnt_q    <= '0;
         awlen_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         beats_q  <= beats_d;
         cnt_q    <= cnt_d;
         awlen_q  <= awlen_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      beats_d  = beats_q;
      cnt_d    = cnt_q;
      awlen_d  = awlen_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.WR_START && bus.WR_LEN != '0) begin
               addr_d   = bus.WR_ADRS & ALIGN_MASK;
               remain_d = bus.WR_LEN;
               err_d    = 1'b0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            beats_d = calc_beats;
            awlen_d = 8'(calc_beats - CW'(1));
            cnt_d   = 8'(calc_beats - CW'(1));
            state_d = S_AW;
         end
         S_AW: begin
            if (bus.M_AXI_AWREADY) state_d = S_W;
         end
         S_W: begin
            if (bus.M_AXI_WREADY) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd0) state_d = S_B;
            end
         end
         S_B: begin
            if (bus.M_AXI_BVALID) begin
               err_d    = err_q | (bus.M_AXI_BRESP != 2'b00);
               addr_d   = addr_q + (ADDR_W'(beats_q) << SZ);
               remain_d = remain_q - LEN_W'(beats_q);
               state_d  = (remain_q != LEN_W'(beats_q)) ? S_CALC : S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.M_AXI_AWID    = AXI_ID;
      bus.M_AXI_AWADDR  = addr_q;
      bus.M_AXI_AWLEN   = awlen_q;
      bus.M_AXI_AWSIZE  = 3'(SZ);
      bus.M_AXI_AWBURST = 2'b01;
      bus.M_AXI_AWLOCK  = 1'b0;
      bus.M_AXI_AWCACHE = 4'b0010;
      bus.M_AXI_AWPROT  = 3'b000;
      bus.M_AXI_AWQOS   = 4'b0000;
      bus.M_AXI_AWVALID = (state_q == S_AW);
      bus.M_AXI_WDATA   = bus.WR_FIFO_DATA;
      bus.M_AXI_WSTRB   = '1;
      bus.M_AXI_WVALID  = (state_q == S_W);
      bus.M_AXI_WLAST   = (state_q == S_W) && (cnt_q == 8'd0);
      bus.M_AXI_BREADY  = (state_q == S_B);
      bus.WR_FIFO_RE    = (state_q == S_W) && bus.M_AXI_WREADY;
      bus.WR_READY      = (state_q == S_IDLE);
      bus.WR_DONE       = (state_q == S_DONE);
      bus.WR_ERR        = err_q;
   end
endmodule

// File: tb/tb_axi_master_write_burst.sv
// tb/tb_axi_master_write_burst.sv - table-driven and randomized bench with a burst-splitting reference model.
module tb_axi_master_write_burst;
   localparam int DATA_W = 64, ADDR_W = 32, ID_W = 4, LEN_W = 16, MAX_BURST = 128, BPB = 8;

   typedef struct { logic [31:0] addr; int len; } burst_t;
   typedef struct {
      logic [31:0] addr; int len; int errb; int awd; int wm; int exp_nb; logic exp_err;
   } vec_t;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   axi_master_write_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus();

   axi_master_write_burst #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(4'hF),
      .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .bus(bus)
   );

   int n_tests = 0, n_fail = 0;
   burst_t exp_q[$];
   int cyc = 0, n_aw, n_wb, wbeat, n_beats, n_re, n_b, n_done, n_wlast;
   int start_cyc, aw_cyc, lastb_cyc, done_cyc;
   logic done_err;
   int aw_delay, wmode, err_burst, aw_wait, fifo_idx, bdelay, bpend;
   bit mon_en = 0, re_pend = 0, b_clear = 0, prev_stall = 0;
   logic [31:0] prev_awaddr;
   logic [7:0] prev_awlen;

   function automatic logic [63:0] pat(input int i);
      return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'h5A5A_0000};
   endfunction

   assign bus.WR_FIFO_DATA = pat(fifo_idx);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: greedy split honouring remaining count, MAX_BURST and the 4 KB page end.
   task automatic build_exp(input logic [31:0] addr, input int len);
      logic [31:0] a;
      int r, b, room;
      exp_q.delete();
      a = addr & ~32'(BPB - 1);
      r = len;
      while (r > 0) begin
         b = (r > MAX_BURST) ? MAX_BURST : r;
         room = (4096 - int'(a[11:0])) / BPB;
         if (b > room) b = room;
         exp_q.push_back('{a, b - 1});
         a = a + 32'(b * BPB);
         r -= b;
      end
   endtask

   task automatic clear_mon();
      n_aw = 0; n_wb = 0; wbeat = 0; n_beats = 0; n_re = 0; n_b = 0; n_done = 0; n_wlast = 0;
      aw_cyc = -1; lastb_cyc = 0; done_cyc = 0; done_err = 1'bx;
      aw_wait = 0; fifo_idx = 0; bpend = 0; bdelay = 0; re_pend = 0; b_clear = 0; prev_stall = 0;
   endtask

   // Slave + monitor: drive readies at negedge, sample handshakes just after.
   initial begin
      bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
      bus.M_AXI_BRESP = 2'b00; bus.M_AXI_BID = '0;
      forever begin
         @(posedge ACLK); #1;
         cyc++;
         if (re_pend) fifo_idx++;
         re_pend = 0;
         @(negedge ACLK);
         if (ARESET || !mon_en) begin
            bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; b_clear = 0;
         end else begin
            bus.M_AXI_AWREADY = (aw_wait >= aw_delay);
            case (wmode)
               0:       bus.M_AXI_WREADY = 1'b1;
               1:       bus.M_AXI_WREADY = ~bus.M_AXI_WREADY;
               default: bus.M_AXI_WREADY = 1'($urandom_range(0, 1));
            endcase
            if (b_clear) begin
               bus.M_AXI_BVALID = 0; b_clear = 0;
            end else if (!bus.M_AXI_BVALID && bpend > 0) begin
               if (bdelay == 0) begin
                  bus.M_AXI_BVALID = 1;
                  bus.M_AXI_BRESP = (n_b == err_burst) ? 2'b10 : 2'b00;
               end else bdelay--;
            end
         end
         #1;
         if (!ARESET && mon_en) begin
            if (prev_stall) begin
               chk("aw_hold_valid", bus.M_AXI_AWVALID, 1);
               chk("aw_hold_addr", bus.M_AXI_AWADDR, prev_awaddr);
               chk("aw_hold_len", bus.M_AXI_AWLEN, prev_awlen);
            end
            prev_stall = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
            prev_awaddr = bus.M_AXI_AWADDR;
            prev_awlen = bus.M_AXI_AWLEN;
            if (bus.M_AXI_WVALID) chk("w_after_aw", n_aw > n_wb, 1);
            if (bus.M_AXI_WVALID || bus.WR_FIFO_RE)
               chk("fifo_re", bus.WR_FIFO_RE, bus.M_AXI_WVALID && bus.M_AXI_WREADY);
            re_pend = bus.WR_FIFO_RE;
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
               logic exp_last;
               exp_last = (n_wb < exp_q.size()) && (wbeat == exp_q[n_wb].len);
               chk("wdata", bus.M_AXI_WDATA, pat(n_beats));
               chk("wstrb", bus.M_AXI_WSTRB, 8'hFF);
               chk("wlast", bus.M_AXI_WLAST, exp_last);
               n_beats++; wbeat++;
               if (bus.WR_FIFO_RE) n_re++;
               if (bus.M_AXI_WLAST) n_wlast++;
               if (exp_last) begin
                  n_wb++; wbeat = 0; bpend++; bdelay = $urandom_range(0, 3);
               end
            end
            if (bus.M_AXI_AWVALID && aw_cyc < 0) aw_cyc = cyc;
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
               if (n_aw < exp_q.size()) begin
                  chk("awaddr", bus.M_AXI_AWADDR, exp_q[n_aw].addr);
                  chk("awlen", bus.M_AXI_AWLEN, 8'(exp_q[n_aw].len));
               end else chk("extra_aw", n_aw + 1, exp_q.size());
               chk("aw_const", {bus.M_AXI_AWID, bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST, bus.M_AXI_AWLOCK,
                                bus.M_AXI_AWCACHE, bus.M_AXI_AWPROT, bus.M_AXI_AWQOS},
                               {4'hF, 3'd3, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
               n_aw++; aw_wait = 0;
            end else if (bus.M_AXI_AWVALID) aw_wait++;
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
               n_b++; bpend--; b_clear = 1; lastb_cyc = cyc;
            end
            if (bus.WR_DONE) begin
               n_done++; done_cyc = cyc; done_err = bus.WR_ERR;
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_awvalid"}, bus.M_AXI_AWVALID, 0);
      chk({tag, "_wvalid"}, bus.M_AXI_WVALID, 0);
      chk({tag, "_bready"}, bus.M_AXI_BREADY, 0);
      chk({tag, "_wlast"}, bus.M_AXI_WLAST, 0);
      chk({tag, "_done"}, bus.WR_DONE, 0);
      chk({tag, "_err"}, bus.WR_ERR, 0);
      chk({tag, "_awaddr"}, bus.M_AXI_AWADDR, 0);
      chk({tag, "_awlen"}, bus.M_AXI_AWLEN, 0);
      chk({tag, "_ready"}, bus.WR_READY, 1);
      chk({tag, "_re"}, bus.WR_FIFO_RE, 0);
   endtask

   task automatic start_req(input logic [31:0] addr, input int len, input int errb, input int awd, input int wm);
      build_exp(addr, len);
      clear_mon();
      err_burst = errb; aw_delay = awd; wmode = wm; mon_en = 1;
      @(negedge ACLK);
      chk("ready_before_start", bus.WR_READY, 1);
      bus.WR_START = 1; bus.WR_ADRS = addr; bus.WR_LEN = LEN_W'(len);
      start_cyc = cyc;
      @(negedge ACLK);
      bus.WR_START = 0;
      #2;
      chk("err_cleared_on_start", bus.WR_ERR, 0);
   endtask

   task automatic do_request(input logic [31:0] addr, input int len, input int errb,
                             input int awd, input int wm, input bit poke);
      int t;
      logic exp_err;
      start_req(addr, len, errb, awd, wm);
      exp_err = (errb >= 0) && (errb < exp_q.size());
      t = 0;
      while (n_done == 0 && t < 8000) begin
         @(negedge ACLK);
         if (poke && t == 6) begin
            bus.WR_START = 1; bus.WR_ADRS = 32'h9000; bus.WR_LEN = 16'd5;
         end else bus.WR_START = 0;
         #2;
         t++;
      end
      bus.WR_START = 0;
      chk("done_seen", n_done, 1);
      chk("n_aw", n_aw, exp_q.size());
      chk("n_beats", n_beats, len);
      chk("n_re", n_re, len);
      chk("n_wlast", n_wlast, exp_q.size());
      chk("n_b", n_b, exp_q.size());
      chk("aw_latency", aw_cyc - start_cyc, 2);
      chk("done_latency", done_cyc - lastb_cyc, 1);
      chk("done_err", done_err, exp_err);
      repeat (2) @(negedge ACLK);
      #2;
      chk("done_one_pulse", n_done, 1);
      chk("ready_after", bus.WR_READY, 1);
      chk("err_held", bus.WR_ERR, exp_err);
   endtask

   vec_t vecs[8];

   initial begin
      int t, seen;
      bus.WR_START = 0; bus.WR_ADRS = '0; bus.WR_LEN = '0;
      vecs[0] = '{32'h0000_1000, 16,  -1, 0, 0, 1, 1'b0};
      vecs[1] = '{32'h0000_0000, 300, -1, 0, 0, 3, 1'b0};
      vecs[2] = '{32'h0000_0FC0, 16,  -1, 0, 0, 2, 1'b0};
      vecs[3] = '{32'h0000_2000, 20,  -1, 5, 1, 1, 1'b0};
      vecs[4] = '{32'h0000_3000, 256,  1, 0, 0, 2, 1'b1};
      vecs[5] = '{32'hFFFF_FFC0, 16,  -1, 2, 2, 2, 1'b0};
      vecs[6] = '{32'h0000_0FFC, 3,   -1, 0, 1, 2, 1'b0};
      vecs[7] = '{32'h0000_7000, 128,  0, 1, 1, 1, 1'b1};

      repeat (3) @(negedge ACLK);
      check_reset_vals("reset");
      ARESET = 0;

      for (int i = 0; i < 8; i++) begin
         do_request(vecs[i].addr, vecs[i].len, vecs[i].errb, vecs[i].awd, vecs[i].wm, 0);
         chk($sformatf("tbl%0d_n_aw", i), n_aw, vecs[i].exp_nb);
         chk($sformatf("tbl%0d_err", i), done_err, vecs[i].exp_err);
      end

      // WR_START while busy must be ignored
      do_request(32'h0000_0100, 40, -1, 0, 0, 1);

      // zero-length request is a no-op
      clear_mon(); exp_q.delete();
      @(negedge ACLK);
      bus.WR_START = 1; bus.WR_ADRS = 32'h4000; bus.WR_LEN = '0;
      @(negedge ACLK);
      bus.WR_START = 0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK); #2;
         if (bus.M_AXI_AWVALID || !bus.WR_READY || bus.WR_DONE) seen++;
      end
      chk("len0_idle", seen, 0);
      chk("len0_no_aw", n_aw, 0);

      // async reset in the middle of the data phase
      start_req(32'h0000_5000, 16, -1, 0, 0);
      t = 0;
      while (n_beats < 5 && t < 500) begin
         @(negedge ACLK); #2; t++;
      end
      chk("midw_reached", n_beats >= 5, 1);
      #1 ARESET = 1;
      #1 check_reset_vals("midw_rst");
      mon_en = 0;
      seen = 0;
      repeat (3) begin
         @(negedge ACLK); #2;
         if (bus.WR_DONE) seen++;
      end
      chk("no_done_after_rst", seen, 0);
      @(negedge ACLK);
      ARESET = 0;
      do_request(32'h0000_6000, 24, -1, 1, 2, 0);

      for (int i = 0; i < 25; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[11:0] = 12'hE00 + 12'($urandom_range(0, 511));
         do_request(a, $urandom_range(1, 400), int'($urandom_range(0, 4)) - 1,
                    $urandom_range(0, 5), $urandom_range(0, 2), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_master_write_burst.md
Name: axi_master_write_burst

Overview:
Parametrised AXI4 write master, next generation of the DDR3 write path. Accepts one user write request of arbitrary beat count and splits it into AXI4 INCR bursts. Each burst is limited by MAX_BURST and never crosses a 4 KB boundary. Drains a first-word-fall-through write FIFO, reports BRESP errors, and sits between the frame-buffer write FIFO and the DDR3 controller AXI slave port.

Parameters:
DATA_W, 64, AXI data width in bits; power of two, 32..512.
ADDR_W, 32, AXI address width.
ID_W, 4, AXI ID width.
AXI_ID, 4'hF, constant value driven on M_AXI_AWID.
MAX_BURST, 128, maximum beats per burst; 1..256.
LEN_W, 16, width of the user total-beat count.

Ports:
ACLK  in  1  AXI clock; all logic on rising edge.
ARESET  in  1  asynchronous, active-high reset.
M_AXI_AWID  out  ID_W  = AXI_ID.
M_AXI_AWADDR  out  ADDR_W  burst start address.
M_AXI_AWLEN  out  8  beats-1.
M_AXI_AWSIZE  out  3  log2(DATA_W/8).
M_AXI_AWBURST  out  2  2'b01 (INCR).
M_AXI_AWLOCK / AWCACHE / AWPROT / AWQOS  out  1/4/3/4  constants 0 / 4'b0010 / 0 / 0.
M_AXI_AWVALID  out  1  address valid.
M_AXI_AWREADY  in  1  address ready.
M_AXI_WDATA  out  DATA_W  = WR_FIFO_DATA.
M_AXI_WSTRB  out  DATA_W/8  all ones.
M_AXI_WLAST  out  1  last beat of current burst.
M_AXI_WVALID  out  1  data valid.
M_AXI_WREADY  in  1  data ready.
M_AXI_BID  in  ID_W  ignored.
M_AXI_BRESP  in  2  write response.
M_AXI_BVALID  in  1  response valid.
M_AXI_BREADY  out  1  response ready.
WR_START  in  1  request pulse; sampled only while WR_READY=1.
WR_ADRS  in  ADDR_W  start byte address; low log2(DATA_W/8) bits forced to 0.
WR_LEN  in  LEN_W  total beats; 0 = no-op.
WR_READY  out  1  high in IDLE.
WR_FIFO_RE  out  1  = WVALID & WREADY.
WR_FIFO_DATA  in  DATA_W  FWFT FIFO head.
WR_DONE  out  1  one-cycle pulse at end of request.
WR_ERR  out  1  any BRESP≠OKAY during request; valid with WR_DONE, held until next accepted WR_START.

Behaviour:
- Reset (async, immediate): state IDLE; AWVALID, WVALID, BREADY, WLAST, WR_DONE, WR_ERR = 0; AWADDR = 0; AWLEN = 0; WR_READY = 1. Reset mid-burst abandons the transaction and emits no WR_DONE.
- States: IDLE → CALC → AW → W → B → (CALC | DONE) → IDLE.
- IDLE: on WR_START with WR_LEN≠0, latch address, latch remaining=WR_LEN, clear WR_ERR, go to CALC. WR_START with WR_LEN=0 is ignored (no pulse). WR_START outside IDLE is ignored.
- CALC (1 cycle):
  - beats = min(remaining, MAX_BURST, (4096 − addr[11:0]) >> log2(DATA_W/8)).
  - AWLEN <= beats−1; beat counter <= beats−1. Use LEN_W+1-bit arithmetic; no truncation.
- AW: AWVALID=1, stable (with AWADDR and AWLEN) until AWREADY. On the handshake cycle, AWVALID→0 and go to W. WVALID is never asserted before the AW handshake.
- W: WVALID=1. Each WVALID&WREADY cycle: WR_FIFO_RE=1 and decrement the beat counter. WLAST = (counter==0) & WVALID. On the last beat, WVALID→0 and go to B. WREADY low stalls with no loss of data; WDATA follows the FIFO head.
- B: BREADY=1. On BVALID, OR (BRESP≠2'b00) into WR_ERR. Then addr += beats×(DATA_W/8) and remaining −= beats. If remaining≠0 go to CALC, else go to DONE. BREADY drops after the handshake.
- DONE: WR_DONE=1 for one cycle, then IDLE.
- Latency: WR_START→AWVALID = 2 cycles. With zero-wait slave, per-burst overhead = CALC+AW+B = 3 cycles plus BVALID delay.
- An error does not abort the request: all bursts are still issued.
- Address wraps modulo 2^ADDR_W; the 4 KB rule still applies at the wrap.

Test Plan:
- DATA_W=64, MAX_BURST=128; WR_ADRS=0x1000, WR_LEN=16, always-ready slave → one burst: AWADDR=0x1000, AWLEN=15; 16 RE pulses; WLAST on the 16th beat; WR_DONE 1 cycle after BVALID handshake +1; WR_ERR=0.
- WR_LEN=300 at 0x0 → three bursts, AWLEN=127,127,43, at 0x0, 0x400, 0x800; exactly 300 RE pulses.
- WR_ADRS=0x0FC0, WR_LEN=16 → two bursts: 0x0FC0 AWLEN=7, then 0x1000 AWLEN=7; no burst crosses 0x1000.
- AWREADY delayed 5 cycles, WREADY toggling 1-0-1-0 → AW signals stable while waiting; RE count equals beat count; data order preserved; WLAST only on the final handshake.
- WR_LEN=256, BRESP=SLVERR on burst 2 only → both bursts complete; WR_ERR=1 at WR_DONE; next WR_START clears it.
- ARESET asserted mid-W after 5 beats → all outputs at reset values asynchronously, no WR_DONE; a fresh request afterwards completes normally. Separately, WR_LEN=0 → stays IDLE, no AWVALID.
